// File: rtl/tx_gear3216_if.sv
// Link-layer and transmitter-facing signals of the TX 32->16 gearbox.
// The link layer is the master; the gearbox is the slave.
interface tx_gear3216_if;
   logic [31:0] data_in;
   logic [3:0]  charisk_in;
   logic        valid_in;
   logic        ready_out;
   logic        force_align;
   logic [15:0] data_out;
   logic [1:0]  charisk_out;
   logic        align_sent;
   logic        fill_sent;

   modport master (
      output data_in, charisk_in, valid_in, force_align,
      input  ready_out, data_out, charisk_out, align_sent, fill_sent
   );

   modport slave (
      input  data_in, charisk_in, valid_in, force_align,
      output ready_out, data_out, charisk_out, align_sent, fill_sent
   );
endinterface

// File: rtl/tx_gear3216.sv
// SATA TX gearbox: one 32-bit dword every two clocks out as 16-bit words, low half first,
// with an ALIGNp pair after every ALIGN_PERIOD non-ALIGN dwords and SYNCp filling idle slots.
module tx_gear3216 #(
   parameter int unsigned ALIGN_PERIOD = 256,
   parameter logic [31:0] ALIGN_PRIM   = 32'h7B4A4ABC,
   parameter logic [31:0] FILL_PRIM    = 32'hB5B5957C
) (
   input logic          clk,
   input logic          rst_n,
   tx_gear3216_if.slave bus
);

   typedef enum logic [1:0] {
      StNormal,
      StAlign1,
      StAlign2
   } state_e;

   localparam logic [15:0] CntLast = 16'(ALIGN_PERIOD - 1);

   state_e      state_q, state_d;
   logic        phase_q;
   logic [31:0] dword_q, dword_d;
   logic [3:0]  k_q, k_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] dataOut_q, dataOut_d;
   logic [1:0]  kOut_q, kOut_d;
   logic        alignSent_q, alignSent_d;
   logic        fillSent_q, fillSent_d;

   // Reset starts in StAlign1 so the first two loads after release are the ALIGNp pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAlign1;
         phase_q     <= 1'b0;
         dword_q     <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         dataOut_q   <= '0;
         kOut_q      <= '0;
         alignSent_q <= 1'b0;
         fillSent_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= ~phase_q;
         dword_q     <= dword_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         dataOut_q   <= dataOut_d;
         kOut_q      <= kOut_d;
         alignSent_q <= alignSent_d;
         fillSent_q  <= fillSent_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dword_d     = dword_q;
      k_d         = k_q;
      alignSent_d = 1'b0;
      fillSent_d  = 1'b0;
      dataOut_d   = phase_q ? dword_q[31:16] : dword_q[15:0];
      kOut_d      = phase_q ? k_q[3:2] : k_q[1:0];

      // Phase 1 is the load slot: the high half leaves while the next dword is chosen.
      if (phase_q) begin
         if (bus.force_align) begin
            dword_d     = ALIGN_PRIM;
            k_d         = 4'h1;
            alignSent_d = 1'b1;
            cnt_d       = '0;
            state_d     = StNormal;
         end else begin
            unique case (state_q)
               StAlign1: begin
                  dword_d     = ALIGN_PRIM;
                  k_d         = 4'h1;
                  alignSent_d = 1'b1;
                  state_d     = StAlign2;
               end
               StAlign2: begin
                  dword_d     = ALIGN_PRIM;
                  k_d         = 4'h1;
                  alignSent_d = 1'b1;
                  state_d     = StNormal;
               end
               default: begin
                  if (bus.valid_in) begin
                     dword_d = bus.data_in;
                     k_d     = bus.charisk_in;
                  end else begin
                     dword_d    = FILL_PRIM;
                     k_d        = 4'h1;
                     fillSent_d = 1'b1;
                  end
                  if (cnt_q == CntLast) begin
                     cnt_d   = '0;
                     state_d = StAlign1;
                  end else begin
                     cnt_d = cnt_q + 16'd1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.ready_out   = phase_q & ~bus.force_align & (state_q == StNormal);
   assign bus.data_out    = dataOut_q;
   assign bus.charisk_out = kOut_q;
   assign bus.align_sent  = alignSent_q;
   assign bus.fill_sent   = fillSent_q;

endmodule

// File: tb/tb_tx_gear3216.sv
// Self-checking bench for tx_gear3216: randomized link-layer source against a queue-based
// model of the transmitted word stream, plus literal checks of the reset sequence.
module tb_tx_gear3216;

   localparam int          P         = 4;
   localparam logic [31:0] AlignPrim = 32'h7B4A4ABC;
   localparam logic [31:0] FillPrim  = 32'hB5B5957C;

   logic        clk;
   logic        rst_n;
   logic [31:0] srcData;
   logic [3:0]  srcK;
   logic        srcValid;
   logic        forceAlign;

   int checks = 0;
   int errors = 0;

   tx_gear3216_if bus ();

   assign bus.data_in     = srcData;
   assign bus.charisk_in  = srcK;
   assign bus.valid_in    = srcValid;
   assign bus.force_align = forceAlign;

   tx_gear3216 #(
      .ALIGN_PERIOD(P),
      .ALIGN_PRIM  (AlignPrim),
      .FILL_PRIM   (FillPrim)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: a queue of 16-bit words still to be transmitted, an ALIGNp debt and a count of
   // non-ALIGN dwords since the last pair. Evaluated mid-cycle for the upcoming edge.
   logic [17:0] mQ[$];
   int          mOwed;
   int          mSent;
   bit          mIsLoad;
   bit          mAccept;
   logic [15:0] expData;
   logic [1:0]  expK;
   logic        expAlign;
   logic        expFill;
   logic        expReady;
   logic [31:0] mDword;
   logic [3:0]  mKflags;
   logic [17:0] mWord;

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset data_out", 32'(bus.data_out), 32'h0);
         checkOutput("reset charisk_out", 32'(bus.charisk_out), 32'h0);
         checkOutput("reset ready_out", 32'(bus.ready_out), 32'h0);
         checkOutput("reset align_sent", 32'(bus.align_sent), 32'h0);
         checkOutput("reset fill_sent", 32'(bus.fill_sent), 32'h0);
         mQ = {};
         mQ.push_back(18'h0);
         mQ.push_back(18'h0);
         mOwed    = 2;
         mSent    = 0;
         mIsLoad  = 1'b0;
         mAccept  = 1'b0;
         expData  = '0;
         expK     = '0;
         expAlign = 1'b0;
         expFill  = 1'b0;
      end else begin
         expReady = mIsLoad && !forceAlign && (mOwed == 0);
         checkOutput("data_out", 32'(bus.data_out), 32'(expData));
         checkOutput("charisk_out", 32'(bus.charisk_out), 32'(expK));
         checkOutput("align_sent", 32'(bus.align_sent), 32'(expAlign));
         checkOutput("fill_sent", 32'(bus.fill_sent), 32'(expFill));
         checkOutput("ready_out", 32'(bus.ready_out), 32'(expReady));

         if (mQ.size() > 0) mWord = mQ.pop_front();
         else mWord = 18'h0;
         expData  = mWord[15:0];
         expK     = mWord[17:16];
         expAlign = 1'b0;
         expFill  = 1'b0;
         mAccept  = 1'b0;
         if (mIsLoad) begin
            if (forceAlign) begin
               mDword = AlignPrim; mKflags = 4'h1; expAlign = 1'b1;
               mOwed = 0; mSent = 0;
            end else if (mOwed > 0) begin
               mDword = AlignPrim; mKflags = 4'h1; expAlign = 1'b1;
               mOwed--;
            end else begin
               if (srcValid) begin
                  mDword = srcData; mKflags = srcK; mAccept = 1'b1;
               end else begin
                  mDword = FillPrim; mKflags = 4'h1; expFill = 1'b1;
               end
               mSent++;
               if (mSent == P) begin
                  mSent = 0;
                  mOwed = 2;
               end
            end
            mQ.push_back({mKflags[1:0], mDword[15:0]});
            mQ.push_back({mKflags[3:2], mDword[31:16]});
         end
         mIsLoad = !mIsLoad;
      end
   end

   // Source holds an offered dword until the model says it was taken.
   task automatic applyStimulus(input int validPct, input bit forceVal, input bit incr);
      @(posedge clk);
      #2;
      if (mAccept || !srcValid) begin
         if (incr) srcData = srcData + 32'd1;
         else srcData = $urandom;
         srcK     = 4'($urandom_range(15));
         srcValid = ($urandom_range(99) < validPct);
      end
      forceAlign = forceVal;
   endtask

   logic [15:0] relData [8];
   logic [1:0]  relK [8];
   int          alignHits;
   int          readyHits;
   int          heldHits;
   bit          hitLoad;

   initial begin
      rst_n      = 1'b0;
      srcData    = 32'h0;
      srcK       = 4'h0;
      srcValid   = 1'b0;
      forceAlign = 1'b0;
      relData = '{16'h0, 16'h0, 16'h4ABC, 16'h7B4A, 16'h4ABC, 16'h7B4A, 16'h957C, 16'hB5B5};
      relK    = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("release word %0d", e + 1), 32'(bus.data_out), 32'(relData[e]));
         checkOutput($sformatf("release k %0d", e + 1), 32'(bus.charisk_out), 32'(relK[e]));
         if (e == 3) begin
            checkOutput("first align_sent", 32'(bus.align_sent), 32'h1);
            checkOutput("ready in cycle 5", 32'(bus.ready_out), 32'h0);
         end
         if (e == 4) checkOutput("first ready in cycle 6", 32'(bus.ready_out), 32'h1);
         if (e == 5) checkOutput("first fill_sent", 32'(bus.fill_sent), 32'h1);
         if (e == 6) checkOutput("fill_sent low", 32'(bus.fill_sent), 32'h0);
      end

      // Continuous data: any 12 consecutive load slots carry exactly two ALIGNp pairs.
      srcData  = 32'h1000_0000;
      srcValid = 1'b1;
      repeat (4) applyStimulus(100, 1'b0, 1'b1);
      alignHits = 0;
      repeat (24) begin
         applyStimulus(100, 1'b0, 1'b1);
         if (bus.align_sent) alignHits++;
      end
      checkOutput("aligns per 12 loads", 32'(alignHits), 32'd4);

      repeat (200) applyStimulus(50, 1'b0, 1'b0);

      repeat (10) applyStimulus(100, 1'b0, 1'b1);
      readyHits = 0;
      repeat (20) begin
         applyStimulus(100, 1'b1, 1'b1);
         #1;
         if (bus.ready_out) readyHits++;
      end
      checkOutput("ready during force", 32'(readyHits), 32'd0);
      repeat (60) applyStimulus(60, 1'b0, 1'b0);

      // Reset in a load cycle while a dword is being offered.
      hitLoad = 1'b0;
      for (int i = 0; i < 4 && !hitLoad; i++) begin
         @(posedge clk);
         #2;
         hitLoad = mIsLoad;
      end
      checkOutput("found load cycle", 32'(hitLoad), 32'h1);
      srcData    = 32'hCAFE_F00D;
      srcK       = 4'h0;
      srcValid   = 1'b1;
      forceAlign = 1'b0;
      rst_n      = 1'b0;
      #1;
      checkOutput("async reset data_out", 32'(bus.data_out), 32'h0);
      checkOutput("async reset charisk_out", 32'(bus.charisk_out), 32'h0);
      checkOutput("async reset ready_out", 32'(bus.ready_out), 32'h0);
      checkOutput("async reset align_sent", 32'(bus.align_sent), 32'h0);
      checkOutput("async reset fill_sent", 32'(bus.fill_sent), 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      heldHits = 0;
      repeat (30) begin
         applyStimulus(0, 1'b0, 1'b0);
         if (bus.data_out == 16'hF00D && bus.charisk_out == 2'b00) heldHits++;
      end
      checkOutput("held dword sent once", 32'(heldHits), 32'd1);
      repeat (60) applyStimulus(70, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
